// File: rtl/pixel_pkg.sv
// Purpose: shared types and geometry helpers for the pixel-array readout controller.
// Latency: n/a (declarations and elaboration-time functions only).
// Backpressure: n/a.
package pixel_pkg;

    // Completed-frame counter width.
    localparam int FRAME_CNT_W = 8;

    // Readout sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_OUTPUT  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Integer square root; the array is square, so this is the side length.
    function automatic int pixel_side(input int num_pixels);
        int s;
        s = 0;
        while ((s + 1) * (s + 1) <= num_pixels) begin
            s = s + 1;
        end
        return s;
    endfunction

    // Address width for one dimension; at least one bit even for a 1x1 array.
    function automatic int pixel_addr_w(input int side);
        int w;
        w = $clog2(side);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pixel_addr_gen.sv
// Purpose: row-major row/column wrap counter for a SIDE x SIDE pixel array.
// Latency: new address visible the cycle after clear/advance.
// Backpressure: none; advances only when the controller commands it.
module pixel_addr_gen #(
    parameter int SIDE   = 2,
    parameter int ADDR_W = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    output logic [ADDR_W-1:0] row,
    output logic [ADDR_W-1:0] col,
    output logic              last
);

    localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(SIDE - 1);

    logic [ADDR_W-1:0] row_q, row_d;
    logic [ADDR_W-1:0] col_q, col_d;

    // Next address: clear wins, otherwise step column and carry into row.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (advance) begin
            if (col_q == MAX_IDX) begin
                col_d = '0;
                row_d = (row_q == MAX_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Address registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = (row_q == MAX_IDX) && (col_q == MAX_IDX);

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Purpose: sequences a frame readout of a square pixel array into a valid/ready stream.
// Latency: 3 cycles per pixel minimum (ADDR, CAPTURE, OUTPUT), DONE adds one per frame.
// Backpressure: out_ready low holds out_data/out_valid/out_last and stalls all array reads.
module pixel_readout_ctrl
    import pixel_pkg::*;
#(
    parameter  int NUM_PIXELS = 4,
    parameter  int DATA_W     = 8,
    localparam int SIDE       = pixel_side(NUM_PIXELS),
    localparam int ADDR_W     = pixel_addr_w(SIDE)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    output logic                   read_en,
    output logic [ADDR_W-1:0]      row_addr,
    output logic [ADDR_W-1:0]      col_addr,
    input  logic [DATA_W-1:0]      pix_data,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    state_t                 state_q,      state_d;
    logic                   read_en_q,    read_en_d;
    logic [DATA_W-1:0]      out_data_q,   out_data_d;
    logic                   out_valid_q,  out_valid_d;
    logic                   out_last_q,   out_last_d;
    logic                   busy_q,       busy_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q,  frame_cnt_d;

    logic addr_clear;
    logic addr_adv;
    logic addr_last;
    logic out_hs;

    assign out_hs = out_valid_q & out_ready;

    pixel_addr_gen #(
        .SIDE   (SIDE),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (addr_clear),
        .advance (addr_adv),
        .row     (row_addr),
        .col     (col_addr),
        .last    (addr_last)
    );

    // Next-state and registered-output logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d      = state_q;
        read_en_d    = 1'b0;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        addr_clear   = 1'b0;
        addr_adv     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Address is held at the origin while idle so every frame starts at (0,0).
                addr_clear = 1'b1;
                if (start && !abort) begin
                    state_d   = ST_ADDR;
                    read_en_d = 1'b1;
                end
            end
            ST_ADDR: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                // Array data arrives one cycle after the read strobe.
                out_data_d  = pix_data;
                out_valid_d = 1'b1;
                out_last_d  = addr_last;
                state_d     = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (out_last_q) begin
                        state_d      = ST_DONE;
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 1'b1;
                        addr_clear   = 1'b1;
                    end else begin
                        addr_adv  = 1'b1;
                        state_d   = ST_ADDR;
                        read_en_d = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // start here is deliberately ignored; a new frame needs a pulse in IDLE.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort && (state_q != ST_IDLE)) begin
            state_d      = ST_IDLE;
            read_en_d    = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            frame_done_d = 1'b0;
            frame_cnt_d  = frame_cnt_q;
            addr_clear   = 1'b1;
            addr_adv     = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset discards any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            read_en_q    <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            read_en_q    <= read_en_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign read_en    = read_en_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Purpose: scoreboard bench for the pixel readout controller (2x2 and 1x1 builds).
// Latency: expected pixels queued at frame start, popped on each observed handshake.
// Backpressure: bench toggles out_ready to exercise output hold.
module tb_pixel_readout_ctrl;

    localparam int AW = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic       read_en;
    logic [AW-1:0] row_addr;
    logic [AW-1:0] col_addr;
    logic [7:0] pix_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_cnt;

    // 1x1 build
    logic       start1;
    logic       abort1;
    logic       read_en1;
    logic [0:0] row1;
    logic [0:0] col1;
    logic [7:0] pix_data1;
    logic [7:0] out_data1;
    logic       out_valid1;
    logic       out_ready1;
    logic       out_last1;
    logic       busy1;
    logic       frame_done1;
    logic [7:0] frame_cnt1;

    typedef struct packed {
        logic [7:0]    d;
        logic [AW-1:0] r;
        logic [AW-1:0] c;
        logic          l;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    pixel_readout_ctrl #(.NUM_PIXELS(4), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .read_en(read_en), .row_addr(row_addr), .col_addr(col_addr),
        .pix_data(pix_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .busy(busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    pixel_readout_ctrl #(.NUM_PIXELS(1), .DATA_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .abort(abort1),
        .read_en(read_en1), .row_addr(row1), .col_addr(col1),
        .pix_data(pix_data1), .out_data(out_data1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_last(out_last1), .busy(busy1),
        .frame_done(frame_done1), .frame_cnt(frame_cnt1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected frame for the 2x2 array: value = 0x10 + row*2 + col.
    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2; c++) begin
                e.d = 8'(8'h10 + r * 2 + c);
                e.r = AW'(r);
                e.c = AW'(c);
                e.l = (r == 1) && (c == 1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic push_pixel0();
        exp_t e;
        e.d = 8'h10;
        e.r = '0;
        e.c = '0;
        e.l = 1'b0;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!frame_done && n < 40) begin
            step();
            n++;
        end
        check(nm, frame_done, 1);
    endtask

    task automatic wait_pix(input int r, input int c, input string nm);
        int n;
        n = 0;
        while (!(out_valid && row_addr == AW'(r) && col_addr == AW'(c)) && n < 40) begin
            step();
            n++;
        end
        check(nm, out_valid, 1);
    endtask

    // Pixel-array model: data for the strobed address is presented only in the cycle after read_en.
    logic       pend_vld = 1'b0;
    logic [7:0] pend_dat = 8'h00;
    always @(negedge clk) begin
        pend_vld = read_en;
        pend_dat = 8'(8'h10 + row_addr * 2 + col_addr);
    end
    initial begin
        pix_data = 8'hEE;
        forever begin
            @(posedge clk);
            #1;
            pix_data = pend_vld ? pend_dat : 8'hEE;
        end
    end

    // Monitor: handshakes against scoreboard, output hold under stall, frame_done placement.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_lastv = 1'b0;
    logic       prev_last_hs = 1'b0;
    always @(negedge clk) begin
        logic hs;
        exp_t e;
        hs = reset_n && !abort && out_valid && out_ready;
        if (prev_hold) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
            check("hold_last", out_last, prev_lastv);
        end
        if (out_valid) begin
            check("no_read_while_valid", read_en, 0);
        end
        if (frame_done || prev_last_hs) begin
            check("frame_done_after_last", frame_done, prev_last_hs);
        end
        if (frame_done) done_cnt++;
        prev_last_hs = 1'b0;
        if (hs) begin
            if (sb.size() == 0) begin
                check("unexpected_handshake", {24'h0, out_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("hs_data", out_data, e.d);
                check("hs_row", row_addr, e.r);
                check("hs_col", col_addr, e.c);
                check("hs_last", out_last, e.l);
                prev_last_hs = e.l;
            end
        end
        prev_hold  = reset_n && !abort && out_valid && !out_ready;
        prev_data  = out_data;
        prev_lastv = out_last;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        reset_n    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        out_ready  = 1'b1;
        start1     = 1'b0;
        abort1     = 1'b0;
        out_ready1 = 1'b1;
        pix_data1  = 8'hA5;
        step(); step(); step();

        // Reset state
        check("rst_read_en", read_en, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_addr", {row_addr, col_addr}, 0);
        check("rst_out_data", out_data, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        reset_n = 1'b1;
        step();

        // Basic frame
        push_frame();
        pulse_start();
        check("f1_read_en_first", read_en, 1);
        check("f1_busy", busy, 1);
        wait_done("f1_done_seen");
        check("f1_frame_cnt", frame_cnt, 1);
        step();
        check("f1_done_one_cycle", frame_done, 0);
        check("f1_idle", busy, 0);
        check("f1_sb_empty", sb.size(), 0);

        // Stall five cycles on pixel 2
        push_frame();
        pulse_start();
        wait_pix(1, 0, "stall_reach_pix2");
        out_ready = 1'b0;
        repeat (5) step();
        check("stall_data", out_data, 8'h12);
        check("stall_valid", out_valid, 1);
        check("stall_no_read", read_en, 0);
        out_ready = 1'b1;
        wait_done("stall_done_seen");
        check("stall_frame_cnt", frame_cnt, 2);
        step();

        // Abort during output of pixel 1
        d0 = done_cnt;
        push_pixel0();
        pulse_start();
        wait_pix(0, 1, "abort_reach_pix1");
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_read_en", read_en, 0);
        check("abort_addr", {row_addr, col_addr}, 0);
        check("abort_frame_cnt", frame_cnt, 2);
        step(); step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_sb_empty", sb.size(), 0);

        // Abort and start together in IDLE
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_start_idle", busy, 0);

        // start during ADDR, CAPTURE and DONE is ignored
        d0 = done_cnt;
        push_frame();
        start = 1'b1;
        step();
        check("ign_in_addr", read_en, 1);
        step();
        step();
        start = 1'b0;
        wait_done("ign_done_seen");
        start = 1'b1;
        step();
        start = 1'b0;
        check("ign_start_in_done", busy, 0);
        step();
        check("ign_still_idle", busy, 0);
        check("ign_one_done", done_cnt - d0, 1);
        check("ign_frame_cnt", frame_cnt, 3);
        check("ign_sb_empty", sb.size(), 0);

        // Reset mid-frame, then a clean frame
        d0 = done_cnt;
        push_pixel0();
        pulse_start();
        wait_pix(0, 1, "rst_reach_pix1");
        reset_n = 1'b0;
        step(); step();
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        check("midrst_addr", {row_addr, col_addr}, 0);
        check("midrst_out_data", out_data, 0);
        reset_n = 1'b1;
        step();
        check("midrst_no_done", done_cnt - d0, 0);
        push_frame();
        pulse_start();
        wait_done("midrst_clean_done");
        check("midrst_clean_cnt", frame_cnt, 1);
        step();

        // Back-to-back frames until the counter wraps
        for (int i = 0; i < 255; i++) begin
            push_frame();
            pulse_start();
            wait_done("wrap_frame_done");
            if (i == 253) check("wrap_cnt_255", frame_cnt, 255);
            step();
        end
        check("wrap_cnt_0", frame_cnt, 0);
        check("wrap_sb_empty", sb.size(), 0);

        // 1x1 array
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        begin
            int n;
            n = 0;
            while (!out_valid1 && n < 10) begin
                step();
                n++;
            end
        end
        check("one_valid", out_valid1, 1);
        check("one_data", out_data1, 8'hA5);
        check("one_last", out_last1, 1);
        check("one_addr", {row1, col1}, 0);
        step();
        check("one_done", frame_done1, 1);
        check("one_frame_cnt", frame_cnt1, 1);
        check("one_addr_after", {row1, col1}, 0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
